// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared CPU encodings for modes, exception causes, vectors and write-port kinds
package cpu_defs_pkg;
  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;
  localparam int EXC_UND  = 0;
  localparam int EXC_SWI  = 1;
  localparam int EXC_PABT = 2;
  localparam int EXC_DABT = 3;
  localparam int EXC_IRQ  = 4;
  localparam int EXC_FIQ  = 5;
  localparam logic [31:0] VEC_UND  = 32'h04;
  localparam logic [31:0] VEC_SWI  = 32'h08;
  localparam logic [31:0] VEC_PABT = 32'h0C;
  localparam logic [31:0] VEC_DABT = 32'h10;
  localparam logic [31:0] VEC_IRQ  = 32'h18;
  localparam logic [31:0] VEC_FIQ  = 32'h1C;
  localparam logic [1:0] KIND_GPR  = 2'd0;
  localparam logic [1:0] KIND_SPSR = 2'd1;
  localparam logic [1:0] KIND_CPSR = 2'd2;
  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;
  localparam int CPSR_I = 7;
  localparam int CPSR_F = 6;
  localparam int CPSR_T = 5;
  typedef enum logic [2:0] {S_IDLE, S_SAVE_SPSR, S_WRITE_LR, S_SET_CPSR, S_SET_PC, S_DONE} seq_state_t;
  function automatic logic [4:0] cause_mode(input logic [5:0] c);
    return c[EXC_FIQ] ? MODE_FIQ : c[EXC_IRQ] ? MODE_IRQ :
           (c[EXC_DABT] | c[EXC_PABT]) ? MODE_ABT : c[EXC_UND] ? MODE_UND : MODE_SVC;
  endfunction
  function automatic logic [31:0] cause_vec(input logic [5:0] c);
    return c[EXC_FIQ] ? VEC_FIQ : c[EXC_IRQ] ? VEC_IRQ : c[EXC_DABT] ? VEC_DABT :
           c[EXC_PABT] ? VEC_PABT : c[EXC_UND] ? VEC_UND : VEC_SWI;
  endfunction
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: masks IRQ/FIQ and picks the highest-priority pending exception as one-hot
module exc_prio_enc
  import cpu_defs_pkg::*;
(
  input  logic [5:0] exc_req,
  input  logic       irq_dis,
  input  logic       fiq_dis,
  output logic [5:0] cause
);
  logic [5:0] elig;
  assign elig = exc_req & ~{fiq_dis, irq_dis, 4'b0000};
  assign cause = elig[EXC_DABT] ? 6'b001000 : elig[EXC_FIQ]  ? 6'b100000 :
                 elig[EXC_IRQ]  ? 6'b010000 : elig[EXC_PABT] ? 6'b000100 :
                 elig[EXC_UND]  ? 6'b000001 : elig[EXC_SWI]  ? 6'b000010 : 6'b000000;
endmodule

// File: rtl/exc_entry_seq.sv
// exc_entry_seq: exception entry sequencer issuing SPSR, LR, CPSR, PC writes over one shared port
module exc_entry_seq
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] VEC_BASE    = 32'h0000_0000,
  parameter logic [31:0] LR_OFS_DABT = 32'd8,
  parameter logic [31:0] LR_OFS_DEF  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  exc_req,
  input  logic [31:0] cpsr_in,
  input  logic [31:0] pc_in,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [1:0]  wr_kind,
  output logic [3:0]  wr_addr,
  output logic [4:0]  wr_mode,
  output logic [31:0] wr_data,
  output logic        stall,
  output logic        flush,
  output logic [5:0]  exc_ack
);
  seq_state_t state;
  logic [5:0] sel, cause;
  logic [31:0] old_cpsr, lr_val, new_cpsr;
  exc_prio_enc u_prio (
    .exc_req(exc_req),
    .irq_dis(cpsr_in[CPSR_I]),
    .fiq_dis(cpsr_in[CPSR_F]),
    .cause(sel)
  );
  // entry always disables IRQ and clears Thumb; FIQ is additionally disabled only on FIQ entry
  assign new_cpsr = {old_cpsr[31:8], 1'b1, old_cpsr[CPSR_F] | cause[EXC_FIQ], 1'b0, cause_mode(cause)};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= S_IDLE;
      cause    <= '0;
      old_cpsr <= '0;
      lr_val   <= '0;
      wr_valid <= 1'b0;
      wr_kind  <= '0;
      wr_addr  <= '0;
      wr_mode  <= '0;
      wr_data  <= '0;
      stall    <= 1'b0;
      flush    <= 1'b0;
      exc_ack  <= '0;
    end else begin
      flush   <= 1'b0;
      exc_ack <= '0;
      case (state)
        S_IDLE: if (|sel) begin
          state    <= S_SAVE_SPSR;
          cause    <= sel;
          old_cpsr <= cpsr_in;
          lr_val   <= pc_in + (sel[EXC_DABT] ? LR_OFS_DABT : LR_OFS_DEF);
          stall    <= 1'b1;
          flush    <= 1'b1;
          wr_valid <= 1'b1;
          wr_kind  <= KIND_SPSR;
          wr_addr  <= 4'd0;
          wr_mode  <= cause_mode(sel);
          wr_data  <= cpsr_in;
        end
        S_SAVE_SPSR: if (wr_ready) begin
          state   <= S_WRITE_LR;
          wr_kind <= KIND_GPR;
          wr_addr <= 4'd14;
          wr_data <= lr_val;
        end
        S_WRITE_LR: if (wr_ready) begin
          state   <= S_SET_CPSR;
          wr_kind <= KIND_CPSR;
          wr_addr <= 4'd0;
          wr_data <= new_cpsr;
        end
        S_SET_CPSR: if (wr_ready) begin
          state   <= S_SET_PC;
          wr_kind <= KIND_GPR;
          wr_addr <= 4'd15;
          wr_data <= VEC_BASE + cause_vec(cause);
        end
        S_SET_PC: if (wr_ready) begin
          state    <= S_DONE;
          wr_valid <= 1'b0;
          wr_kind  <= '0;
          wr_addr  <= '0;
          wr_mode  <= '0;
          wr_data  <= '0;
          exc_ack  <= cause;
        end
        default: begin
          state <= S_IDLE;
          stall <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_exc_entry_seq.sv
// tb_exc_entry_seq: directed checks of exception entry write order, priority, masking, backpressure and reset
module tb_exc_entry_seq;
  typedef struct packed {
    logic [1:0]  k;
    logic [3:0]  a;
    logic [4:0]  m;
    logic [31:0] d;
  } wr_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  exc_req = '0;
  logic [31:0] cpsr_in = '0;
  logic [31:0] pc_in = '0;
  logic        wr_ready = 1'b1;
  logic        wr_valid, stall, flush;
  logic [1:0]  wr_kind;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_mode;
  logic [31:0] wr_data;
  logic [5:0]  exc_ack;
  logic        hi_valid, hi_stall, hi_flush;
  logic [1:0]  hi_kind;
  logic [3:0]  hi_addr;
  logic [4:0]  hi_mode;
  logic [31:0] hi_data;
  logic [5:0]  hi_ack;
  logic [31:0] hi_pc = '0;
  logic        any_act = 1'b0;
  wr_t         wq[$];
  int          n_chk = 0;
  int          n_fail = 0;

  exc_entry_seq dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .cpsr_in(cpsr_in), .pc_in(pc_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_kind(wr_kind), .wr_addr(wr_addr),
    .wr_mode(wr_mode), .wr_data(wr_data), .stall(stall), .flush(flush), .exc_ack(exc_ack)
  );
  exc_entry_seq #(.VEC_BASE(32'hFFFF_0000)) dut_hi (
    .clk(clk), .rst(rst), .exc_req(exc_req), .cpsr_in(cpsr_in), .pc_in(pc_in),
    .wr_valid(hi_valid), .wr_ready(wr_ready), .wr_kind(hi_kind), .wr_addr(hi_addr),
    .wr_mode(hi_mode), .wr_data(hi_data), .stall(hi_stall), .flush(hi_flush), .exc_ack(hi_ack)
  );

  always #5 clk = ~clk;

  // log each handshake that will complete at the coming rising edge
  always @(negedge clk) begin
    #1;
    if (wr_valid && wr_ready) wq.push_back('{wr_kind, wr_addr, wr_mode, wr_data});
    if (hi_valid && wr_ready && hi_kind == 2'd0 && hi_addr == 4'd15) hi_pc = hi_data;
    if (stall || flush || wr_valid || exc_ack != 0) any_act = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic pop_write(input string tag, input logic [1:0] k, input logic [3:0] a,
                           input logic [4:0] m, input logic [31:0] d);
    wr_t w;
    check({tag, " queued"}, 32'(wq.size() != 0), 32'd1);
    if (wq.size() != 0) begin
      w = wq.pop_front();
      check({tag, " ctl"}, {21'd0, w.k, w.a, w.m}, {21'd0, k, a, m});
      check({tag, " data"}, w.d, d);
    end
  endtask

  task automatic check_entry(input string tag, input int lat, input logic [4:0] m,
                             input logic [31:0] spsr, input logic [31:0] lr,
                             input logic [31:0] cpsr, input logic [31:0] pc, input logic [5:0] ack);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exc_ack == 0 && n < 30);
    check({tag, " ack"}, 32'(exc_ack), 32'(ack));
    check({tag, " latency"}, n, lat);
    check({tag, " ack stall"}, 32'(stall), 32'd1);
    pop_write({tag, " spsr"}, 2'd1, 4'd0, m, spsr);
    pop_write({tag, " lr"}, 2'd0, 4'd14, m, lr);
    pop_write({tag, " cpsr"}, 2'd2, 4'd0, m, cpsr);
    pop_write({tag, " pc"}, 2'd0, 4'd15, m, pc);
    check({tag, " extra writes"}, 32'(wq.size()), 32'd0);
  endtask

  task automatic ack_done(input string tag);
    @(negedge clk);
    check({tag, " ack one cycle"}, 32'(exc_ack), 32'd0);
    check({tag, " valid low"}, 32'(wr_valid), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    check("reset state", {wr_valid, stall, flush, exc_ack, wr_kind, wr_addr, wr_mode}, 32'd0);
    check("reset data", wr_data, 32'd0);
    rst = 1'b0;
    // SWI from USR
    cpsr_in = 32'h10; pc_in = 32'h100; exc_req = 6'b000010;
    @(negedge clk);
    check("swi first stall", 32'(stall), 32'd1);
    check("swi first flush", 32'(flush), 32'd1);
    check("swi first valid", 32'(wr_valid), 32'd1);
    @(negedge clk);
    check("swi flush one cycle", 32'(flush), 32'd0);
    check_entry("swi", 3, 5'b10011, 32'h10, 32'h104, 32'h93, 32'h08, 6'b000010);
    check("swi hi pc", hi_pc, 32'hFFFF_0008);
    exc_req = '0;
    ack_done("swi");
    check("swi stall released", 32'(stall), 32'd0);
    // DABT beats FIQ and IRQ, FIQ follows
    pc_in = 32'h200; exc_req = 6'b111000;
    check_entry("dabt", 5, 5'b10111, 32'h10, 32'h208, 32'h97, 32'h10, 6'b001000);
    exc_req = 6'b110000;
    ack_done("dabt");
    check_entry("fiq after dabt", 5, 5'b10001, 32'h10, 32'h204, 32'hD1, 32'h1C, 6'b100000);
    exc_req = '0;
    ack_done("fiq after dabt");
    // masked IRQ does nothing
    cpsr_in = 32'h90; pc_in = 32'h300; exc_req = 6'b010000;
    @(negedge clk);
    any_act = 1'b0;
    repeat (8) @(negedge clk);
    check("masked irq activity", 32'(any_act), 32'd0);
    check("masked irq stall", 32'(stall), 32'd0);
    check("masked irq writes", 32'(wq.size()), 32'd0);
    // unmask the same IRQ
    cpsr_in = 32'h10;
    check_entry("irq", 5, 5'b10010, 32'h10, 32'h304, 32'h92, 32'h18, 6'b010000);
    exc_req = '0;
    ack_done("irq");
    // FIQ from SYS
    cpsr_in = 32'h1F; pc_in = 32'h400; exc_req = 6'b100000;
    check_entry("fiq sys", 5, 5'b10001, 32'h1F, 32'h404, 32'hD1, 32'h1C, 6'b100000);
    check("fiq hi pc", hi_pc, 32'hFFFF_001C);
    exc_req = '0;
    ack_done("fiq sys");
    // UND with backpressure during the LR write
    cpsr_in = 32'h10; pc_in = 32'h500; exc_req = 6'b000001;
    repeat (2) @(negedge clk);
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("und hold ctl", {21'd0, wr_valid, wr_kind, wr_addr, wr_mode}, {21'd0, 1'b1, 2'd0, 4'd14, 5'b11011});
      check("und hold data", wr_data, 32'h504);
      @(negedge clk);
    end
    wr_ready = 1'b1;
    check_entry("und", 3, 5'b11011, 32'h10, 32'h504, 32'h9B, 32'h04, 6'b000001);
    exc_req = '0;
    ack_done("und");
    // reset during SET_CPSR, request still held
    pc_in = 32'h600; exc_req = 6'b000010;
    repeat (3) @(negedge clk);
    check("pre-reset kind", 32'(wr_kind), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async reset outputs", {wr_valid, stall, flush, exc_ack, wr_kind, wr_addr, wr_mode}, 32'd0);
    check("async reset data", wr_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete();
    check_entry("post reset swi", 5, 5'b10011, 32'h10, 32'h604, 32'h93, 32'h08, 6'b000010);
    exc_req = '0;
    ack_done("post reset swi");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exc_entry_seq.md
Name: exc_entry_seq

Overview:
- Exception-entry sequencer for the CPU's banked register file.
- Detects and prioritises pending exceptions, masking IRQ/FIQ from CPSR.
- Drives one shared register-bank write port for four writes in order: SPSR, banked LR, CPSR, PC.
- Stalls and flushes the pipeline for the whole sequence; the write port is arbitrated upstream via a valid/ready handshake.

Parameters:
- VEC_BASE, 32'h0000_0000, exception vector table base (32'hFFFF_0000 for high vectors).
- LR_OFS_DABT, 8, LR offset added to pc_in for data abort.
- LR_OFS_DEF, 4, LR offset added to pc_in for all other causes.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- exc_req  in  6  level requests; bit0 UND, 1 SWI, 2 PABT, 3 DABT, 4 IRQ, 5 FIQ.
- cpsr_in  in  32  current CPSR.
- pc_in  in  32  address used as LR base.
- wr_valid  out  1  write-port request.
- wr_ready  in  1  write-port grant; transfer occurs when wr_valid && wr_ready at a rising edge.
- wr_kind  out  2  write target: 0 GPR, 1 SPSR, 2 CPSR.
- wr_addr  out  4  GPR index, valid when wr_kind=0.
- wr_mode  out  5  bank mode for the write.
- wr_data  out  32  write data.
- stall  out  1  holds the pipeline.
- flush  out  1  one-cycle pipeline flush.
- exc_ack  out  6  one-hot, one-cycle acknowledge of the taken cause.

Behaviour:
- Reset
  - State IDLE; all outputs 0; capture registers 0.
  - rst mid-sequence aborts immediately; partial writes are not undone.
- Masking: IRQ is eligible only if cpsr_in[7]==0; FIQ is eligible only if cpsr_in[6]==0.
- Priority, highest first: DABT > FIQ > IRQ > PABT > UND > SWI.
- IDLE
  - Requests are sampled only in IDLE.
  - If any eligible request is present at a rising edge, capture cause, old_cpsr=cpsr_in, lr_val=pc_in+offset (mod 2^32), then go to SAVE_SPSR.
  - stall=1 and flush=1 in the cycle after capture; flush lasts one cycle only.
  - Requests arriving outside IDLE are ignored; sources hold level until acked.
- Modes and vectors by cause:
  - UND: mode 11011, vector +0x04.
  - SWI: mode 10011, vector +0x08.
  - PABT: mode 10111, vector +0x0C.
  - DABT: mode 10111, vector +0x10.
  - IRQ: mode 10010, vector +0x18.
  - FIQ: mode 10001, vector +0x1C.
- State sequence (wr_valid=1 in each write state; hold all write outputs stable until wr_ready, then advance):
  - SAVE_SPSR: kind=1, mode=new mode, data=old_cpsr.
  - WRITE_LR: kind=0, addr=14, mode=new mode, data=lr_val.
  - SET_CPSR: kind=2, mode=new mode, data = old_cpsr with [4:0]=new mode, [5](T)=0, [7](I)=1, [6](F)=1 if FIQ else unchanged.
  - SET_PC: kind=0, addr=15, mode=new mode, data=VEC_BASE+vector offset.
  - DONE: wr_valid=0, exc_ack=captured one-hot for one cycle, stall=1, then IDLE (stall=0).
- Latency with wr_ready tied to 1: request sampled at edge N; writes occur at edges N+1..N+4; exc_ack high in the cycle after N+4; earliest re-entry sample at edge N+6.
- wr_ready low stretches the current state indefinitely; no write is skipped or duplicated.
- New mode equal to old mode (e.g., SWI from SVC) is sequenced normally.

Decomposition:
- Shared package cpu_defs_pkg:
  - mode encodings (USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111);
  - exception cause bit indices;
  - vector offsets;
  - wr_kind codes;
  - CPSR bit positions (N/Z/C/V 31:28, I 7, F 6, T 5, M 4:0);
  - sequencer state enum.
- Sub-module exc_prio_enc: combinational mask-plus-priority encoder producing a one-hot cause; all sequencing stays in the top module.

Test Plan:
- SWI only, cpsr_in=32'h0000_0010, pc_in=32'h100, wr_ready=1 -> four writes in order:
  - SPSR(mode 10011)=32'h10;
  - R14=32'h104;
  - CPSR=32'h93;
  - R15=32'h08;
  - exc_ack=6'b000010 one cycle later.
- exc_req=6'b111000 (DABT+IRQ+FIQ), cpsr_in=32'h10, pc_in=32'h200 -> DABT taken:
  - R14=32'h208, CPSR=32'h97, R15=32'h10, exc_ack=6'b001000;
  - FIQ/IRQ resampled on return to IDLE, FIQ taken next.
- IRQ with cpsr_in[7]=1 -> no activity, stall=0.
- Same IRQ with cpsr_in[7]=0 -> IRQ entry, CPSR=32'h92.
- FIQ, cpsr_in=32'h1F, VEC_BASE=32'hFFFF_0000 -> CPSR=32'hD1, R15=32'hFFFF_001C.
- UND with wr_ready low for 3 cycles during WRITE_LR -> wr_addr/wr_data/wr_mode held stable; exactly one LR write; ack delayed by 3 cycles.
- rst asserted during SET_CPSR -> outputs 0 asynchronously; IDLE after release; a still-held request starts a fresh sequence from SAVE_SPSR.
